// File: rtl/der_izq_pkg.sv
// rtl/der_izq_pkg.sv - shared constants, state encoding and counter sizing for the serial adder
package der_izq_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Bit counter width for an arbitrary WIDTH; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/der_izq_full_adder.sv
// rtl/der_izq_full_adder.sv - combinational 1-bit full adder
module der_izq_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/der_izq_serial_alu.sv
// rtl/der_izq_serial_alu.sv - LSB-first bit-serial adder; DER_IZQ_SUB_EN adds a subtract mode via port sub
module der_izq_serial_alu
    import der_izq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DER_IZQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] b_cap;
    logic             carry_init;

`ifdef DER_IZQ_SUB_EN
    // Two's complement subtract: invert B and inject a carry of one.
    assign b_cap      = sub ? ~B : B;
    assign carry_init = sub;
`else
    assign b_cap      = B;
    assign carry_init = 1'b0;
`endif

    der_izq_full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_nxt)
    );

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            S     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= b_cap;
                        carry <= carry_init;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= {sum_bit, r_sr[WIDTH-1:1]};
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    // S is only ever loaded with a complete result.
                    if (cnt == LAST) begin
                        S     <= {sum_bit, r_sr[WIDTH-1:1]};
                        cout  <= carry_nxt;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/der_izq_serial_alu.md
Name: der_izq_serial_alu

Overview:
- Bit-serial adder that processes two WIDTH-bit operands one bit per clock, right to left (LSB first).
- Sits directly downstream of the operand-pair test source, which drives A and B with 5-bit operand pairs.
- Accepts an operand pair on a start pulse, iterates WIDTH cycles, then presents the registered sum and carry with a one-cycle done strobe.

Parameters:
- WIDTH, 5, operand and result width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin an operation; sampled on rising clk
- A  input  WIDTH  operand A; captured when start is accepted
- B  input  WIDTH  operand B; captured when start is accepted
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle strobe; S and cout are valid and new
- S  output  WIDTH  result, registered, held until the next done
- cout  output  1  final carry out, registered, held with S

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, S=0, cout=0.
  - Internal operand registers, counter and carry are cleared; any operation in flight is discarded.
- States:
  - IDLE: start=1 at an edge -> latch A and B into shift registers, carry=0, cnt=0 -> SHIFT. start=0 -> stay.
  - SHIFT (busy=1): each edge computes sum bit = a0^b0^carry and carry = maj(a0,b0,carry). The sum bit is shifted into an internal result register from the MSB side; both operand registers shift right; cnt++.
    - On the edge where cnt==WIDTH-1 (the last bit): load S from the completed internal result and cout from the final carry -> DONE.
    - start is ignored in SHIFT; A and B changes are ignored.
  - DONE (done=1, busy=0, exactly one cycle): start=1 -> accept new operands as in IDLE -> SHIFT. start=0 -> IDLE.
- Latency:
  - start accepted at edge t0 -> done high in the cycle following edge t0+WIDTH.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- S and cout change only at the edge entering DONE. Partial results are never visible on S.
- Width rule: S = (A+B) mod 2^WIDTH; cout = bit WIDTH of A+B.
- start held high continuously: a new operation restarts on every DONE cycle.

Optional Feature:
- Macro: DER_IZQ_SUB_EN
- Defined:
  - Extra input port sub (1 bit), captured with A and B at start acceptance.
  - sub=1: B is inverted at capture and the initial carry is 1, so S = (A-B) mod 2^WIDTH and cout=1 means no borrow (A>=B).
  - sub=0: identical to the add-only behaviour.
- Undefined: the sub port does not exist; add only.

Decomposition:
- Shared package der_izq_pkg:
  - state typedef (IDLE, SHIFT, DONE) with a 2-bit encoding.
  - counter width constant, $clog2(WIDTH).
  - default WIDTH constant = 5.
- One sub-module, der_izq_full_adder: combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once in the SHIFT datapath.

Test Plan:
- Reset mid-SHIFT: assert reset 2 cycles after start -> busy=0, done=0, S=0, cout=0 immediately (asynchronous); no done follows after release.
- A=11001, B=10010, start pulse -> after 5 cycles done=1 for one cycle, S=01011, cout=1; S holds 01011 afterwards.
- Back-to-back with start held high: pairs (11101,01100) -> S=01001, cout=1; then (00101,10001) -> S=10110, cout=0. Done pulses are 6 cycles apart.
- A=01111, B=00111, and start re-pulsed while busy -> the extra start is ignored; single done with S=10110, cout=0.
- Boundary: A=11111, B=00001 -> S=00000, cout=1. A=00000, B=00000 -> S=00000, cout=0.
- DER_IZQ_SUB_EN defined:
  - sub=1, A=11001, B=10010 -> S=00111, cout=1.
  - sub=1, A=00101, B=10001 -> S=10100, cout=0.
